// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot time-division demultiplexer.
// Rebuilds four parallel lanes from a slot-serial stream that is aligned by a
// frame-sync marker. Each completed frame is presented as one word on a
// valid/ready output. Every output is driven straight from a register.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               in_valid,
  input  logic               frame_sync,
  output logic [4*WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         slot,
  output logic               locked,
  output logic               sync_err,
  output logic               overflow,
  input  logic               ovf_clr
);

  // HUNT discards beats until the first frame_sync arrives.
  // SYNC is only left through reset.
  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_slot;
  logic [WIDTH-1:0]   r_lane [4];
  logic [4*WIDTH-1:0] r_outData;
  logic               r_outValid;
  logic               r_locked;
  logic               r_syncErr;
  logic               r_overflow;

  state_t             w_stateNext;
  logic [1:0]         w_slotNext;
  logic [3:0]         w_laneWe;
  logic               w_syncErrNext;
  logic               w_frameDone;
  logic               w_loadOut;
  logic               w_drop;
  logic [4*WIDTH-1:0] w_frameWord;

  // Next-state and lane-write decode for the accepted beat.
  always_comb begin
    w_stateNext   = r_state;
    w_slotNext    = r_slot;
    w_laneWe      = 4'b0000;
    w_syncErrNext = 1'b0;
    w_frameDone   = 1'b0;
    case (r_state)
      HUNT: begin
        if (in_valid && frame_sync) begin
          w_laneWe[0] = 1'b1;
          w_slotNext  = 2'd1;
          w_stateNext = SYNC;
        end
      end
      SYNC: begin
        if (in_valid) begin
          if (frame_sync) begin
            // A sync beat always restarts the frame at lane 0. Lanes 1-2
            // that belong to a discarded partial frame are overwritten
            // before the next completion, so they never need clearing.
            w_laneWe[0]   = 1'b1;
            w_slotNext    = 2'd1;
            w_syncErrNext = (r_slot != 2'd0);
          end else begin
            w_laneWe[r_slot] = 1'b1;
            w_slotNext       = r_slot + 2'd1;
            w_frameDone      = (r_slot == 2'd3);
          end
        end
      end
      default: begin
        w_stateNext = HUNT;
        w_slotNext  = 2'd0;
      end
    endcase
  end

  // Lane 3 is taken from din directly, so a frame can be published on the
  // same edge that accepts its last beat.
  assign w_frameWord = {din, r_lane[2], r_lane[1], r_lane[0]};
  assign w_loadOut   = w_frameDone && (!r_outValid || out_ready);
  assign w_drop      = w_frameDone && r_outValid && !out_ready;

  // State register, slot counter, lock flag and sync error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HUNT;
      r_slot    <= 2'd0;
      r_locked  <= 1'b0;
      r_syncErr <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_slot    <= w_slotNext;
      r_locked  <= (w_stateNext == SYNC);
      r_syncErr <= w_syncErrNext;
    end
  end

  // Shadow lanes that collect the current frame beat by beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_lane[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_laneWe[k]) begin
          r_lane[k] <= din;
        end
      end
    end
  end

  // Output word and valid flag. The word stays frozen until it is consumed.
  // Completion together with acceptance loads the new word and keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
    end else if (w_loadOut) begin
      r_outData  <= w_frameWord;
      r_outValid <= 1'b1;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Sticky overflow flag. A drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_data  = r_outData;
  assign out_valid = r_outValid;
  assign slot      = r_slot;
  assign locked    = r_locked;
  assign sync_err  = r_syncErr;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed self-checking bench for tdm_demux4 with WIDTH=4.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
module tb_tdm_demux4;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           in_valid;
  logic           frame_sync;
  logic [4*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     slot;
  logic           locked;
  logic           sync_err;
  logic           overflow;
  logic           ovf_clr;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .in_valid   (in_valid),
    .frame_sync (frame_sync),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one valid beat, clock it in, then settle 1 ns past the edge.
  task automatic applyStimulus(input logic [W-1:0] d, input logic s);
    in_valid   = 1'b1;
    din        = d;
    frame_sync = s;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    frame_sync = 1'b0;
  endtask

  // One cycle with no valid beat.
  task automatic idleCycle();
    in_valid   = 1'b0;
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Directed sequence.
  initial begin
    rst_n      = 1'b0;
    din        = '0;
    in_valid   = 1'b0;
    frame_sync = 1'b0;
    out_ready  = 1'b1;
    ovf_clr    = 1'b0;
    #12;
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_out_data",  out_data,       16'h0000);
    checkOutput("rst_locked",    16'(locked),    16'h0);
    checkOutput("rst_slot",      16'(slot),      16'h0);
    checkOutput("rst_sync_err",  16'(sync_err),  16'h0);
    checkOutput("rst_overflow",  16'(overflow),  16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1,0,1,0 with the consumer ready.
    applyStimulus(4'h1, 1'b1);
    checkOutput("f1_locked", 16'(locked), 16'h1);
    checkOutput("f1_slot1",  16'(slot),   16'h1);
    applyStimulus(4'h0, 1'b0);
    applyStimulus(4'h1, 1'b0);
    checkOutput("f1_no_early_valid", 16'(out_valid), 16'h0);
    applyStimulus(4'h0, 1'b0);
    checkOutput("f1_valid", 16'(out_valid), 16'h1);
    checkOutput("f1_data",  out_data,       16'h0101);
    checkOutput("f1_slot0", 16'(slot),      16'h0);
    idleCycle();
    checkOutput("f1_valid_drop", 16'(out_valid), 16'h0);

    // Two back-to-back frames A,B,C,D and 1,2,3,4.
    applyStimulus(4'hA, 1'b1);
    applyStimulus(4'hB, 1'b0);
    applyStimulus(4'hC, 1'b0);
    applyStimulus(4'hD, 1'b0);
    checkOutput("b2b_valid_a", 16'(out_valid), 16'h1);
    checkOutput("b2b_data_a",  out_data,       16'hDCBA);
    applyStimulus(4'h1, 1'b1);
    checkOutput("b2b_accept_a", 16'(out_valid), 16'h0);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'h4, 1'b0);
    checkOutput("b2b_valid_b", 16'(out_valid), 16'h1);
    checkOutput("b2b_data_b",  out_data,       16'h4321);
    idleCycle();

    // A gap of idle cycles inside a frame holds slot.
    applyStimulus(4'h5, 1'b1);
    idleCycle();
    idleCycle();
    checkOutput("gap_slot_hold", 16'(slot), 16'h1);
    frame_sync = 1'b1;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
    checkOutput("gap_sync_no_valid", 16'(slot), 16'h1);
    checkOutput("gap_no_sync_err",   16'(sync_err), 16'h0);
    applyStimulus(4'h6, 1'b0);
    applyStimulus(4'h7, 1'b0);
    applyStimulus(4'h8, 1'b0);
    checkOutput("gap_data", out_data, 16'h8765);
    idleCycle();

    // A misplaced sync on the 3rd beat restarts the frame.
    applyStimulus(4'h2, 1'b1);
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'h5, 1'b1);
    checkOutput("serr_pulse",    16'(sync_err),  16'h1);
    checkOutput("serr_slot",     16'(slot),      16'h1);
    checkOutput("serr_no_valid", 16'(out_valid), 16'h0);
    applyStimulus(4'h6, 1'b0);
    checkOutput("serr_one_cycle", 16'(sync_err), 16'h0);
    applyStimulus(4'h7, 1'b0);
    applyStimulus(4'h8, 1'b0);
    checkOutput("serr_valid", 16'(out_valid), 16'h1);
    checkOutput("serr_data",  out_data,       16'h8765);
    idleCycle();

    // Overflow while the consumer stalls. A clear on the drop cycle loses to the set.
    out_ready = 1'b0;
    applyStimulus(4'h1, 1'b1);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'h4, 1'b0);
    checkOutput("ovf_first_data", out_data, 16'h4321);
    checkOutput("ovf_not_yet",    16'(overflow), 16'h0);
    applyStimulus(4'h5, 1'b1);
    applyStimulus(4'h6, 1'b0);
    applyStimulus(4'h7, 1'b0);
    ovf_clr = 1'b1;
    applyStimulus(4'h8, 1'b0);
    ovf_clr = 1'b0;
    checkOutput("ovf_set_wins",  16'(overflow),  16'h1);
    checkOutput("ovf_data_kept", out_data,       16'h4321);
    checkOutput("ovf_valid",     16'(out_valid), 16'h1);
    ovf_clr = 1'b1;
    idleCycle();
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared", 16'(overflow), 16'h0);

    // Completion while the pending word is accepted keeps valid high.
    applyStimulus(4'h9, 1'b1);
    applyStimulus(4'hA, 1'b0);
    applyStimulus(4'hB, 1'b0);
    checkOutput("cmp_acc_hold", out_data, 16'h4321);
    out_ready = 1'b1;
    applyStimulus(4'hC, 1'b0);
    checkOutput("cmp_acc_valid", 16'(out_valid), 16'h1);
    checkOutput("cmp_acc_data",  out_data,       16'hCBA9);
    checkOutput("cmp_acc_noovf", 16'(overflow),  16'h0);
    idleCycle();
    checkOutput("cmp_acc_consumed", 16'(out_valid), 16'h0);

    // An asynchronous reset mid-frame drops a pending word and the partial frame.
    out_ready = 1'b0;
    applyStimulus(4'h7, 1'b1);
    applyStimulus(4'h8, 1'b0);
    applyStimulus(4'h9, 1'b0);
    applyStimulus(4'hA, 1'b0);
    checkOutput("mrst_pending", out_data, 16'hA987);
    applyStimulus(4'h5, 1'b1);
    applyStimulus(4'h6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_valid",  16'(out_valid), 16'h0);
    checkOutput("mrst_data",   out_data,       16'h0000);
    checkOutput("mrst_locked", 16'(locked),    16'h0);
    checkOutput("mrst_slot",   16'(slot),      16'h0);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Beats before any sync are ignored. Frame 1,1,0,0 then decodes.
    applyStimulus(4'hF, 1'b0);
    applyStimulus(4'hF, 1'b0);
    applyStimulus(4'hF, 1'b0);
    checkOutput("hunt_locked", 16'(locked), 16'h0);
    checkOutput("hunt_slot",   16'(slot),   16'h0);
    applyStimulus(4'h1, 1'b1);
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h0, 1'b0);
    applyStimulus(4'h0, 1'b0);
    checkOutput("hunt_valid", 16'(out_valid), 16'h1);
    checkOutput("hunt_data",  out_data,       16'h0011);
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
